user_ram_checker: RTL

- User-side traffic generator and checker for the fabric master's dual-port user RAM interface.
- Replaces the free-running address/data counters and the static rd/wr enables that currently drive that interface.
- On `start`, after `ram_init_done`, it writes a deterministic pattern to every address, reads every address back, and compares the returned data.
- Reports pass/fail, error count and first failing address. It sits directly upstream of the RAM write/read ports and consumes `rdata_user`.

---
 rtl/user_ram_chk_pkg.sv | 24 ++
 rtl/user_ram_chk_scoreboard.sv | 76 +++++++
 rtl/user_ram_checker.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/user_ram_chk_pkg.sv
// Shared types, constants and the pattern function for the user RAM checker.
package user_ram_chk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitInit,
    StWrite,
    StRead,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_SAT = 8'd255;

  // Wide result; callers truncate to their data width, which gives the modulo wrap.
  function automatic logic [31:0] data(input logic [31:0] addr, input logic [31:0] seed,
                                       input logic inv);
    logic [31:0] v;
    v = seed + addr;
    return inv ? ~v : v;
  endfunction

endpackage

// File: rtl/user_ram_chk_scoreboard.sv
// Read-data scoreboard: delays {valid, addr, expected} by the RAM read latency, then compares,
// counts mismatches (saturating) and captures the first failing address.
module user_ram_chk_scoreboard
  import user_ram_chk_pkg::*;
#(
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 push_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    exp_i,
  input  logic [DATA_W-1:0]    rdata_i,
  output logic [ERR_CNT_W-1:0] err_count_o,
  output logic [ADDR_W-1:0]    first_err_addr_o
);

  logic              valid_q [READ_LATENCY];
  logic [ADDR_W-1:0] addr_q  [READ_LATENCY];
  logic [DATA_W-1:0] exp_q   [READ_LATENCY];

  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [ADDR_W-1:0]    first_q, first_d;
  logic                 mismatch;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
        exp_q[i]   <= '0;
      end
    end else begin
      valid_q[0] <= push_i;
      addr_q[0]  <= addr_i;
      exp_q[0]   <= exp_i;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
        exp_q[i]   <= exp_q[i-1];
      end
    end
  end

  assign mismatch = valid_q[READ_LATENCY-1] && (rdata_i != exp_q[READ_LATENCY-1]);

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    if (clr_i) begin
      err_d   = '0;
      first_d = '0;
    end else if (mismatch) begin
      if (err_q != ERR_SAT) err_d = err_q + 1'b1;
      // A zero count means no earlier mismatch in this run.
      if (err_q == '0) first_d = addr_q[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q   <= '0;
      first_q <= '0;
    end else begin
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/user_ram_checker.sv
// Write-all / read-all pattern checker for the fabric master's user RAM port.
// Define USER_RAM_CHK_INV_PASS_EN to add a second pass with the inverted pattern.
module user_ram_checker
  import user_ram_chk_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 6,
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       DEPTH        = 64,
  parameter logic [DATA_W-1:0] SEED         = DATA_W'(8'h5A),
  parameter int unsigned       READ_LATENCY = 1
) (
  input  logic                 Clock,
  input  logic                 DEVRST_N,
  input  logic                 start,
  input  logic                 ram_init_done,
  input  logic [DATA_W-1:0]    rdata_user,
  output logic [ADDR_W-1:0]    waddr_user,
  output logic [DATA_W-1:0]    wdata_user,
  output logic                 wr_enable_user,
  output logic [ADDR_W-1:0]    raddr_user,
  output logic                 rd_enable_user,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr
);

  localparam int unsigned      CntW     = ADDR_W + 1;
  localparam logic [CntW-1:0]  LastCnt  = CntW'(DEPTH - 1);
  localparam logic [CntW-1:0]  DrainEnd = CntW'(READ_LATENCY);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              wr_en, rd_en, clr, pat_inv;
  logic [DATA_W-1:0] pat;

  // Only starts seen in IDLE/DONE are kept; anything else is dropped here.
  assign start_d = start && (state_q inside {StIdle, StDone});
  assign clr     = start_d;

`ifdef USER_RAM_CHK_INV_PASS_EN
  logic inv_q, inv_d;
  assign pat_inv = inv_q;
`else
  assign pat_inv = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
`ifdef USER_RAM_CHK_INV_PASS_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start_q) state_d = StWaitInit;
      end
      StWaitInit: begin
        cnt_d = '0;
`ifdef USER_RAM_CHK_INV_PASS_EN
        inv_d = 1'b0;
`endif
        if (ram_init_done) state_d = StWrite;
      end
      StWrite: begin
        wr_en = 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StRead;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRead: begin
        rd_en = 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        if (cnt_q == DrainEnd) begin
          cnt_d   = '0;
`ifdef USER_RAM_CHK_INV_PASS_EN
          if (!inv_q) begin
            inv_d   = 1'b1;
            state_d = StWrite;
          end else begin
            state_d = StDone;
          end
`else
          state_d = StDone;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result flags drop on the edge that samples a restart.
  assign done_d = (state_q == StDone) && !start_q && !start_d;
  assign pass_d = done_d && (err_count == '0);

  always_ff @(posedge Clock) begin
    if (!DEVRST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef USER_RAM_CHK_INV_PASS_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef USER_RAM_CHK_INV_PASS_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign pat = DATA_W'(data(32'(cnt_q), 32'(SEED), pat_inv));

  assign wr_enable_user = wr_en;
  assign waddr_user     = wr_en ? cnt_q[ADDR_W-1:0] : '0;
  assign wdata_user     = wr_en ? pat : '0;
  assign rd_enable_user = rd_en;
  assign raddr_user     = rd_en ? cnt_q[ADDR_W-1:0] : '0;
  assign busy           = state_q inside {StWaitInit, StWrite, StRead, StDrain};
  assign done           = done_q;
  assign pass           = pass_q;

  user_ram_chk_scoreboard #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .READ_LATENCY(READ_LATENCY)
  ) u_scoreboard (
    .clk_i           (Clock),
    .rst_ni          (DEVRST_N),
    .clr_i           (clr),
    .push_i          (rd_en),
    .addr_i          (cnt_q[ADDR_W-1:0]),
    .exp_i           (pat),
    .rdata_i         (rdata_user),
    .err_count_o     (err_count),
    .first_err_addr_o(first_err_addr)
  );

endmodule
